div_sequencer: RTL

Multi-cycle divide sequencer for the RV32M divide and remainder instructions (DIV, DIVU, REM, REMU) executed in the EX stage of the two-stage core. It accepts a start request from the control unit together with the EX-stage operands, runs a 32-iteration restoring divider, and drives `stall_EX` so that the F->EX and EX->WB pipeline registers hold until the result is ready. The result is presented for exactly one cycle, and the EX->WB register captures it through the ALU-result writeback path.

---
 rtl/div_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// div_sequencer
//   Multi-cycle RV32M divide/remainder sequencer (DIV, DIVU, REM, REMU) for the
//   EX stage. A 32-iteration restoring divider works on operand magnitudes; the
//   sign correction and the RISC-V special cases (divide by zero, signed
//   overflow) are applied when the result register is loaded on entry to DONE.
//   stall_EX holds the F->EX and EX->WB registers until the result is ready.
//
// Optional build macro:
//   DIV_EARLY_OUT_EN - when defined, a zero divisor or the signed-overflow pair
//                      skips the iteration and goes IDLE -> DONE directly.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   EX holds a divide instruction
//   funct3       in   100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a         in   dividend
//   op_b         in   divisor
//   kill         in   abort the operation in progress
//   stall_EX     out  hold the F->EX and EX->WB registers this cycle
//   result_valid out  one-cycle pulse, result is valid
//   result       out  registered quotient or remainder
module div_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            stall_EX,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Latched operation context
  logic [CNT_W-1:0] cnt;
  logic             is_rem;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic             sgn_ovf;
  logic [XLEN-1:0]  dividend;
  logic [XLEN-1:0]  divisor;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  quo;

  // Control strobes from the FSM
  logic accept;
  logic early;
  logic iter_en;
  logic finish;

  // funct3[2] is implied by start; only the low bits select the operation
  logic f3_unused;
  assign f3_unused = funct3[2];

  // Operand decode in IDLE
  logic            is_signed_in;
  logic            dz_in;
  logic            ovf_in;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  // One restoring iteration
  logic [XLEN:0]          rem_sh;
  logic signed [XLEN+1:0] trial;
  logic                   q_bit;
  logic [XLEN-1:0]        rem_it;
  logic [XLEN-1:0]        quo_it;

  function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v);
    // The most negative value maps onto itself, which is its correct
    // unsigned magnitude.
    return v[XLEN-1] ? XLEN'(-v) : XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] mag,
                                                 input logic            neg);
    return neg ? (XLEN'(0) - mag) : mag;
  endfunction

  function automatic logic [XLEN-1:0] final_result(
    input logic            rem_op,
    input logic            dz,
    input logic            ovf,
    input logic            nq,
    input logic            nr,
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r,
    input logic [XLEN-1:0] a
  );
    if (dz)
      return rem_op ? a : '1;
    if (ovf)
      return rem_op ? '0 : SMIN;
    return rem_op ? apply_sign(r, nr) : apply_sign(q, nq);
  endfunction

  always_comb begin
    is_signed_in = ~funct3[0];
    dz_in        = (op_b == '0);
    ovf_in       = is_signed_in && (op_a == SMIN) && (op_b == '1);
    mag_a        = is_signed_in ? abs_val(op_a) : op_a;
    mag_b        = is_signed_in ? abs_val(op_b) : op_b;
  end

  // rem is always below divisor, so the shifted value needs one extra bit and
  // the trial subtraction one more for its sign.
  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    trial  = $signed({1'b0, rem_sh}) - $signed({2'b00, divisor});
    q_bit  = ~trial[XLEN+1];
    rem_it = q_bit ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_it = {quo[XLEN-2:0], q_bit};
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // FSM: next state and outputs
  always_comb begin
    state_nxt    = state;
    stall_EX     = 1'b0;
    result_valid = 1'b0;
    accept       = 1'b0;
    early        = 1'b0;
    iter_en      = 1'b0;
    finish       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !kill) begin
          accept   = 1'b1;
          stall_EX = 1'b1;
          early    = EARLY_OUT && (dz_in || ovf_in);
          state_nxt = early ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (kill) begin
          state_nxt = IDLE;
        end else begin
          stall_EX = 1'b1;
          iter_en  = 1'b1;
          if (cnt == '0) begin
            finish    = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        // start is ignored here: the same instruction is still in EX
        result_valid = !kill;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      is_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      sgn_ovf  <= 1'b0;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      result   <= '0;
    end else begin
      if (accept) begin
        cnt      <= CNT_W'(XLEN - 1);
        is_rem   <= funct3[1];
        neg_q    <= is_signed_in && (op_a[XLEN-1] ^ op_b[XLEN-1]);
        neg_r    <= is_signed_in && op_a[XLEN-1];
        div_zero <= dz_in;
        sgn_ovf  <= ovf_in;
        dividend <= op_a;
        divisor  <= mag_b;
        rem      <= '0;
        quo      <= mag_a;
        if (early)
          result <= final_result(funct3[1], dz_in, ovf_in, 1'b0, 1'b0,
                                 '0, '0, op_a);
      end
      if (iter_en) begin
        rem <= rem_it;
        quo <= quo_it;
        if (cnt != '0)
          cnt <= cnt - 1'b1;
      end
      // Load the corrected result from the final iteration's values
      if (finish)
        result <= final_result(is_rem, div_zero, sgn_ovf, neg_q, neg_r,
                               quo_it, rem_it, dividend);
    end
  end

endmodule
